// File: rtl/light_mode_sequencer.sv
// Bike-lamp mode controller: the button cycles OFF/STEADY/BLINK/FADE, and a slow step tick
// sequences the brightness word sent to the pwm block. Low battery caps brightness at half.
module light_mode_sequencer #(
  parameter int CTR_LEN     = 3,
  parameter int TICK_DIV    = 1250000,
  parameter int BLINK_TICKS = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               btn,
  input  logic               low_batt,
  output logic [1:0]         mode,
  output logic               lamp_on,
  output logic [CTR_LEN-1:0] pulse_width
);

  localparam logic [1:0] MODE_OFF    = 2'd0;
  localparam logic [1:0] MODE_STEADY = 2'd1;
  localparam logic [1:0] MODE_BLINK  = 2'd2;
  localparam logic [1:0] MODE_FADE   = 2'd3;

  localparam int TW = $clog2(TICK_DIV);
  localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

  localparam logic [CTR_LEN-1:0] MAX        = '1;
  localparam logic [TW-1:0]      TICK_LAST  = TW'(TICK_DIV - 1);
  localparam logic [BW-1:0]      BLINK_LAST = BW'(BLINK_TICKS - 1);

  logic               btn_q;
  logic [1:0]         mode_q, mode_d;
  logic               lamp_on_q, lamp_on_d;
  logic [CTR_LEN-1:0] pw_q, pw_d;
  logic [TW-1:0]      tick_cnt_q, tick_cnt_d;
  logic [CTR_LEN-1:0] level_q, level_d;
  logic               dir_q, dir_d;
  logic               phase_q, phase_d;
  logic [BW-1:0]      blink_cnt_q, blink_cnt_d;

  logic               btn_edge;
  logic               tick;
  logic [CTR_LEN-1:0] cap;

  always_comb begin
    cap      = low_batt ? (MAX >> 1) : MAX;
    btn_edge = btn & ~btn_q;
    tick     = (tick_cnt_q == TICK_LAST);

    mode_d      = mode_q;
    level_d     = level_q;
    dir_d       = dir_q;
    phase_d     = phase_q;
    blink_cnt_d = blink_cnt_q;

    // A press restarts the step timebase so every pattern begins aligned to the press.
    tick_cnt_d = (btn_edge || tick) ? '0 : tick_cnt_q + TW'(1);

    if (btn_edge) begin
      mode_d      = mode_q + 2'd1;
      level_d     = '0;
      dir_d       = 1'b1;
      phase_d     = 1'b1;
      blink_cnt_d = '0;
    end else if (tick) begin
      case (mode_q)
        MODE_BLINK: begin
          if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d = '0;
            phase_d     = ~phase_q;
          end else begin
            blink_cnt_d = blink_cnt_q + BW'(1);
          end
        end
        MODE_FADE: begin
          // The >= test also pulls level back under a cap lowered mid-ramp.
          if (dir_q) begin
            if (level_q < cap) begin
              level_d = level_q + CTR_LEN'(1);
            end else begin
              level_d = cap;
              dir_d   = 1'b0;
            end
          end else if (level_q != '0) begin
            level_d = level_q - CTR_LEN'(1);
          end else begin
            dir_d = 1'b1;
          end
        end
        default: ;
      endcase
    end

    lamp_on_d = (mode_d != MODE_OFF);

    case (mode_q)
      MODE_STEADY: pw_d = cap;
      MODE_BLINK:  pw_d = phase_q ? cap : '0;
      MODE_FADE:   pw_d = (level_q < cap) ? level_q : cap;
      default:     pw_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      btn_q       <= 1'b1;
      mode_q      <= MODE_OFF;
      lamp_on_q   <= 1'b0;
      pw_q        <= '0;
      tick_cnt_q  <= '0;
      level_q     <= '0;
      dir_q       <= 1'b1;
      phase_q     <= 1'b1;
      blink_cnt_q <= '0;
    end else begin
      btn_q       <= btn;
      mode_q      <= mode_d;
      lamp_on_q   <= lamp_on_d;
      pw_q        <= pw_d;
      tick_cnt_q  <= tick_cnt_d;
      level_q     <= level_d;
      dir_q       <= dir_d;
      phase_q     <= phase_d;
      blink_cnt_q <= blink_cnt_d;
    end
  end

  assign mode        = mode_q;
  assign lamp_on     = lamp_on_q;
  assign pulse_width = pw_q;

endmodule

// File: tb/tb_light_mode_sequencer.sv
// Directed bench for light_mode_sequencer with a 4-cycle step tick and 2-tick blink half-period.
module tb_light_mode_sequencer;

  localparam int CTR_LEN     = 3;
  localparam int TICK_DIV    = 4;
  localparam int BLINK_TICKS = 2;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               btn = 1'b1;
  logic               low_batt = 1'b0;
  logic [1:0]         mode;
  logic               lamp_on;
  logic [CTR_LEN-1:0] pulse_width;

  int checks   = 0;
  int failures = 0;

  // Expected FADE output after tick k (k = 0 is before the first tick). low_batt rises
  // while level is 6 on the second up-ramp, after which the ramp runs against cap = 3.
  int fade_tbl [33] = '{0, 1, 2, 3, 4, 5, 6, 7, 7, 6, 5, 4, 3, 2, 1, 0, 0,
                        1, 2, 3, 4, 5, 6,
                        3, 2, 1, 0, 0, 1, 2, 3, 3, 2};

  light_mode_sequencer #(
    .CTR_LEN    (CTR_LEN),
    .TICK_DIV   (TICK_DIV),
    .BLINK_TICKS(BLINK_TICKS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn        (btn),
    .low_batt   (low_batt),
    .mode       (mode),
    .lamp_on    (lamp_on),
    .pulse_width(pulse_width)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end else begin
      $display("ok   %s: %0d", tag, obs);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Raise btn so the edge is taken at the next clock, then check the new mode.
  task automatic press_edge(input int exp_mode);
    btn = 1'b1;
    step();
    check("press_mode", mode, exp_mode);
    check("press_lamp", lamp_on, (exp_mode != 0) ? 1 : 0);
    btn = 1'b0;
  endtask

  initial begin
    int exp_pw;

    // Reset with the button held, then keep holding it after release.
    step();
    step();
    check("rst_mode", mode, 0);
    check("rst_pw", pulse_width, 0);
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check("held_mode", mode, 0);
      check("held_lamp", lamp_on, 0);
      check("held_pw", pulse_width, 0);
    end
    btn = 1'b0;
    step();
    step();

    // Mode cycle through all four modes and back.
    press_edge(1); step(); check("steady_pw", pulse_width, 7);
    press_edge(2); step(); check("blink_pw", pulse_width, 7);
    press_edge(3); step(); check("fade_pw", pulse_width, 0);
    press_edge(0); step(); check("off_pw", pulse_width, 0);
    press_edge(1); step(); check("steady2_pw", pulse_width, 7);

    // BLINK: 8 cycles on, 8 off, then on again; cap to 3 while on.
    press_edge(2);
    for (int c = 1; c <= 20; c++) begin
      step();
      check("blink_pw", pulse_width, (((c - 1) / 8) % 2 == 0) ? 7 : 0);
    end
    low_batt = 1'b1;
    step();
    for (int c = 22; c <= 25; c++) begin
      step();
      check("blink_lb_pw", pulse_width, (c <= 24) ? 3 : 0);
    end
    low_batt = 1'b0;

    // FADE full triangle, then low_batt raised at level 6 on the way up.
    press_edge(3);
    for (int c = 1; c <= 132; c++) begin
      step();
      exp_pw = fade_tbl[(c - 1) / 4];
      if (c == 91 || c == 92) exp_pw = 3;
      check("fade_pw", pulse_width, exp_pw);
      if (c == 90) low_batt = 1'b1;
    end
    low_batt = 1'b0;

    // Back to BLINK, then press exactly on the fourth cycle when the tick fires.
    press_edge(0); step();
    press_edge(1); step();
    press_edge(2);
    for (int c = 1; c <= 3; c++) begin
      step();
      check("blink_pre_pw", pulse_width, 7);
    end
    press_edge(3);
    for (int c = 1; c <= 21; c++) begin
      step();
      check("tickpress_pw", pulse_width, fade_tbl[(c - 1) / 4]);
    end

    // Reset pulse mid-FADE at level 5.
    rst = 1'b0;
    step();
    check("midrst_mode", mode, 0);
    check("midrst_lamp", lamp_on, 0);
    check("midrst_pw", pulse_width, 0);
    rst = 1'b1;
    step();
    check("postrst_pw", pulse_width, 0);
    step();
    press_edge(1);
    step();
    check("postrst_steady_pw", pulse_width, 7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
